// File: rtl/rv32_wb_pkg.sv
// Shared types for the writeback arbiter: request payload, arbiter state and a destination decoder.
// XLEN and AW match the core data width and register address width.
package rv32_wb_pkg;

    localparam int XLEN = 32;
    localparam int AW = 5;

    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
    } wb_req_t;

    typedef enum logic {
        PRI_EX  = 1'b0,
        PRI_LSU = 1'b1
    } arb_state_e;

    // One-hot destination decode; x0 never produces a hit.
    function automatic logic [NUM_REGS-1:0] reg_dec(input logic [AW-1:0] wa, input logic en);
        logic [NUM_REGS-1:0] hit;
        hit = {NUM_REGS{1'b0}};
        if (en && (wa != {AW{1'b0}})) begin
            hit[wa] = 1'b1;
        end else begin
            hit = {NUM_REGS{1'b0}};
        end
        return hit;
    endfunction

endpackage

// File: rtl/rv32_wb_fifo.sv
// DEPTH-entry writeback request FIFO; an extra pointer bit separates full from empty.
module rv32_wb_fifo
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  wb_req_t din_i,
    input  logic    pop_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_q, wr_d, rd_q, rd_d;
    wb_req_t     mem_q [DEPTH];
    logic        push_ok_s, pop_ok_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_q[PW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok_s) begin
            wr_d = wr_q + {{PW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + {{PW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= {(PW+1){1'b0}};
            rd_q <= {(PW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(AW+XLEN){1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_q[PW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Round-robin sharing of the register-file write port between EX and LSU, with per-register pending tracking.
// Optional WB_ARB_BYPASS_EN: an empty requester that wins arbitration writes straight through the same cycle.
module rv32_wb_arbiter
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [AW-1:0]       ex_wa,
    input  logic [XLEN-1:0]     ex_wd,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [AW-1:0]       lsu_wa,
    input  logic [XLEN-1:0]     lsu_wd,
    output logic                rf_wen,
    output logic [AW-1:0]       rf_wa,
    output logic [XLEN-1:0]     rf_wd,
    output logic [NUM_REGS-1:0] pend_vec,
    output logic                idle
);
    wb_req_t             ex_in_s, lsu_in_s, ex_head_s, lsu_head_s, ex_src_s, lsu_src_s;
    logic                ex_full_s, ex_empty_s, lsu_full_s, lsu_empty_s;
    logic                ex_cand_s, lsu_cand_s, grant_ex_s, grant_lsu_s;
    logic                ex_byp_s, lsu_byp_s, ex_push_s, lsu_push_s, ex_pop_s, lsu_pop_s;
    arb_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q [NUM_REGS];
    logic [CW-1:0]       cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] ex_inc_s, lsu_inc_s, ex_dec_s, lsu_dec_s;

    assign ex_in_s   = {ex_wa, ex_wd};
    assign lsu_in_s  = {lsu_wa, lsu_wd};
    assign ex_ready  = !rst && !ex_full_s;
    assign lsu_ready = !rst && !lsu_full_s;

`ifdef WB_ARB_BYPASS_EN
    // An empty FIFO with a live request competes as if that request were already queued.
    assign ex_cand_s  = !rst && (!ex_empty_s || ex_valid);
    assign lsu_cand_s = !rst && (!lsu_empty_s || lsu_valid);
    assign ex_src_s   = ex_empty_s ? ex_in_s : ex_head_s;
    assign lsu_src_s  = lsu_empty_s ? lsu_in_s : lsu_head_s;
    assign ex_byp_s   = grant_ex_s && ex_empty_s;
    assign lsu_byp_s  = grant_lsu_s && lsu_empty_s;
`else
    assign ex_cand_s  = !rst && !ex_empty_s;
    assign lsu_cand_s = !rst && !lsu_empty_s;
    assign ex_src_s   = ex_head_s;
    assign lsu_src_s  = lsu_head_s;
    assign ex_byp_s   = 1'b0;
    assign lsu_byp_s  = 1'b0;
`endif

    assign ex_push_s  = ex_valid && ex_ready && !ex_byp_s;
    assign lsu_push_s = lsu_valid && lsu_ready && !lsu_byp_s;
    assign ex_pop_s   = grant_ex_s && !ex_empty_s;
    assign lsu_pop_s  = grant_lsu_s && !lsu_empty_s;

    rv32_wb_fifo #(.DEPTH(DEPTH)) u_ex_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ex_push_s),
        .din_i   (ex_in_s),
        .pop_i   (ex_pop_s),
        .head_o  (ex_head_s),
        .full_o  (ex_full_s),
        .empty_o (ex_empty_s)
    );

    rv32_wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (lsu_push_s),
        .din_i   (lsu_in_s),
        .pop_i   (lsu_pop_s),
        .head_o  (lsu_head_s),
        .full_o  (lsu_full_s),
        .empty_o (lsu_empty_s)
    );

    // Round-robin grant and preference update.
    always_comb begin
        state_d     = state_q;
        grant_ex_s  = 1'b0;
        grant_lsu_s = 1'b0;
        case (state_q)
            PRI_EX: begin
                grant_ex_s  = ex_cand_s;
                grant_lsu_s = lsu_cand_s && !ex_cand_s;
            end
            PRI_LSU: begin
                grant_lsu_s = lsu_cand_s;
                grant_ex_s  = ex_cand_s && !lsu_cand_s;
            end
            default: begin
                grant_ex_s  = 1'b0;
                grant_lsu_s = 1'b0;
            end
        endcase
        if (grant_ex_s) begin
            state_d = PRI_LSU;
        end else if (grant_lsu_s) begin
            state_d = PRI_EX;
        end else begin
            state_d = state_q;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRI_EX;
        end else begin
            state_q <= state_d;
        end
    end

    // Write port driven from the granted head; x0 entries drain without a write.
    always_comb begin
        rf_wen = 1'b0;
        rf_wa  = {AW{1'b0}};
        rf_wd  = {XLEN{1'b0}};
        if (grant_ex_s) begin
            rf_wa  = ex_src_s.wa;
            rf_wd  = ex_src_s.wd;
            rf_wen = (ex_src_s.wa != {AW{1'b0}});
        end else if (grant_lsu_s) begin
            rf_wa  = lsu_src_s.wa;
            rf_wd  = lsu_src_s.wd;
            rf_wen = (lsu_src_s.wa != {AW{1'b0}});
        end else begin
            rf_wen = 1'b0;
        end
    end

    assign ex_inc_s  = reg_dec(ex_wa, ex_push_s);
    assign lsu_inc_s = reg_dec(lsu_wa, lsu_push_s);
    assign ex_dec_s  = reg_dec(ex_head_s.wa, ex_pop_s);
    assign lsu_dec_s = reg_dec(lsu_head_s.wa, lsu_pop_s);

    // Pending-counter next-state; both sources may hit the same register in one cycle.
    always_comb begin
        cnt_d[0] = {CW{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r] + CW'(ex_inc_s[r]) + CW'(lsu_inc_s[r])
                     - CW'(ex_dec_s[r]) - CW'(lsu_dec_s[r]);
        end
    end

    // Pending-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= {CW{1'b0}};
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Pending vector and idle flag.
    always_comb begin
        pend_vec = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            pend_vec[r] = !rst && (cnt_q[r] != {CW{1'b0}});
        end
        idle = rst || (ex_empty_s && lsu_empty_s);
    end

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Bench for rv32_wb_arbiter: directed scenarios plus a queue-based reference model checked every cycle.
module tb_rv32_wb_arbiter;
    import rv32_wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = 3;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                ex_valid, ex_ready, lsu_valid, lsu_ready;
    logic [AW-1:0]       ex_wa, lsu_wa, rf_wa;
    logic [XLEN-1:0]     ex_wd, lsu_wd, rf_wd;
    logic                rf_wen, idle;
    logic [NUM_REGS-1:0] pend_vec;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_wa     (ex_wa),
        .ex_wd     (ex_wd),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_wa    (lsu_wa),
        .lsu_wd    (lsu_wd),
        .rf_wen    (rf_wen),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pend_vec  (pend_vec),
        .idle      (idle)
    );

    // Reference model: two request queues and a "prefer LSU next" flag.
    wb_req_t exq[$];
    wb_req_t lq[$];
    bit      pref_lsu = 1'b0;
    bit      m_gex, m_gl, m_exn, m_ln, m_exr, m_lr;

    always @(negedge clk) begin : monitor
        bit                  ex_c, l_c, e_wen, e_idle;
        wb_req_t             w;
        logic [NUM_REGS-1:0] e_pend;
        logic [AW+XLEN+NUM_REGS+3:0] got, exp;
        #2;
        m_exn  = exq.size() > 0;
        m_ln   = lq.size() > 0;
        m_exr  = !rst && (exq.size() < DEPTH);
        m_lr   = !rst && (lq.size() < DEPTH);
        ex_c   = !rst && (m_exn || (BYP && ex_valid));
        l_c    = !rst && (m_ln || (BYP && lsu_valid));
        m_gex  = ex_c && (!l_c || !pref_lsu);
        m_gl   = l_c && !m_gex;
        w      = '0;
        if (m_gex) w = m_exn ? exq[0] : {ex_wa, ex_wd};
        else if (m_gl) w = m_ln ? lq[0] : {lsu_wa, lsu_wd};
        e_wen  = (m_gex || m_gl) && (w.wa != 0);
        e_pend = '0;
        if (!rst) begin
            foreach (exq[i]) if (exq[i].wa != 0) e_pend[exq[i].wa] = 1'b1;
            foreach (lq[i]) if (lq[i].wa != 0) e_pend[lq[i].wa] = 1'b1;
        end
        e_idle = rst || (!m_exn && !m_ln);
        got = {ex_ready, lsu_ready, rf_wen, rf_wa, rf_wd, pend_vec, idle};
        exp = {m_exr, m_lr, e_wen, w.wa, w.wd, e_pend, e_idle};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model_cycle t=%0t got={exr,lr,wen,wa,wd,pend,idle}=%h expected=%h", $time, got, exp);
        end
    end

    always @(posedge clk) begin : model_update
        if (rst) begin
            exq.delete();
            lq.delete();
            pref_lsu <= 1'b0;
        end else begin
            if (ex_valid && m_exr && !(m_gex && !m_exn)) exq.push_back({ex_wa, ex_wd});
            if (lsu_valid && m_lr && !(m_gl && !m_ln)) lq.push_back({lsu_wa, lsu_wd});
            if (m_gex && m_exn) void'(exq.pop_front());
            if (m_gl && m_ln) void'(lq.pop_front());
            if (m_gex) pref_lsu <= 1'b1;
            else if (m_gl) pref_lsu <= 1'b0;
        end
    end

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            total++;
            if ({ex_ready, lsu_ready, rf_wen, rf_wa, rf_wd, pend_vec, idle} !== {3'b000, 5'd0, 32'd0, 32'd0, 1'b1}) begin
                bad++;
                $display("FAIL reset_outputs got rdy=%b%b wen=%b wa=%0d wd=%h pend=%h idle=%b required 00 0 0 0 0 1",
                         ex_ready, lsu_ready, rf_wen, rf_wa, rf_wd, pend_vec, idle);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({ex_ready, lsu_ready, rf_wen, pend_vec, idle} !== {3'b110, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_release got rdy=%b%b wen=%b pend=%h idle=%b required 11 0 0 1",
                     ex_ready, lsu_ready, rf_wen, pend_vec, idle);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        ex_valid = 1'b1; ex_wa = 5'd5; ex_wd = 32'hDEADBEEF;
        #1;
        total++;
`ifdef WB_ARB_BYPASS_EN
        if (rf_wen !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_bypass got wen=%b wa=%0d wd=%h required 1 5 deadbeef", rf_wen, rf_wa, rf_wd);
        end
`else
        if (rf_wen !== 1'b0) begin
            bad++;
            $display("FAIL single_latency got wen=%b required 0", rf_wen);
        end
`endif
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        total++;
`ifdef WB_ARB_BYPASS_EN
        if (rf_wen !== 1'b0 || pend_vec[5] !== 1'b0) begin
            bad++;
            $display("FAIL single_bypass_after got wen=%b pend5=%b required 0 0", rf_wen, pend_vec[5]);
        end
`else
        if (rf_wen !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF || pend_vec[5] !== 1'b1) begin
            bad++;
            $display("FAIL single_write got wen=%b wa=%0d wd=%h pend5=%b required 1 5 deadbeef 1",
                     rf_wen, rf_wa, rf_wd, pend_vec[5]);
        end
`endif
        @(negedge clk);
        #1;
        total++;
        if (pend_vec[5] !== 1'b0 || rf_wen !== 1'b0 || idle !== 1'b1) begin
            bad++;
            $display("FAIL single_clear got pend5=%b wen=%b idle=%b required 0 0 1", pend_vec[5], rf_wen, idle);
        end
    endtask

    task automatic test_alternate;
        int exp_seq[8] = '{1, 11, 2, 12, 3, 13, 4, 14};
        int wr_wa[$];
        int wr_cyc[$];
        int ek = 0;
        int lk = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ex_valid  = (ek < 4); ex_wa  = 5'(1 + ek);  ex_wd  = 32'hE000_0000 + 32'(ek);
            lsu_valid = (lk < 4); lsu_wa = 5'(11 + lk); lsu_wd = 32'hC000_0000 + 32'(lk);
            #1;
            if (rf_wen) begin
                wr_wa.push_back(int'(rf_wa));
                wr_cyc.push_back(c);
            end
            if (ex_valid && ex_ready) ek++;
            if (lsu_valid && lsu_ready) lk++;
        end
        ex_valid = 1'b0; lsu_valid = 1'b0;
        total++;
        if (wr_wa.size() != 8) begin
            bad++;
            $display("FAIL alt_count got %0d writes required 8", wr_wa.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (wr_wa[i] != exp_seq[i]) begin
                    bad++;
                    $display("FAIL alt_order idx=%0d got x%0d required x%0d", i, wr_wa[i], exp_seq[i]);
                end
            end
            total++;
            if (wr_cyc[7] - wr_cyc[0] != 7) begin
                bad++;
                $display("FAIL alt_gapless got span=%0d required 7", wr_cyc[7] - wr_cyc[0]);
            end
        end
    endtask

    task automatic test_full;
        int  ek = 0, lk = 0, acc_l = 0, wr_l = 0;
        bit  was_full = 1'b0, lgrant = 1'b0, done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            ex_valid  = 1'b1; ex_wa  = 5'(1 + ek % 8);  ex_wd  = 32'hA000_0000 + 32'(ek);
            lsu_valid = 1'b1; lsu_wa = 5'(20 + lk % 8); lsu_wd = 32'hB000_0000 + 32'(lk);
            #1;
            if (was_full) begin
                total++;
                if (lsu_ready !== lgrant) begin
                    bad++;
                    $display("FAIL full_ready got lsu_ready=%b required %b", lsu_ready, lgrant);
                end
                if (lgrant) done = 1'b1;
            end else if (lsu_ready === 1'b0) begin
                total++;
                if (acc_l - wr_l != DEPTH) begin
                    bad++;
                    $display("FAIL full_occupancy got %0d queued required %0d", acc_l - wr_l, DEPTH);
                end
                was_full = 1'b1;
            end
            lgrant = rf_wen && (rf_wa >= 5'd20);
            if (lsu_valid && lsu_ready) begin acc_l++; lk++; end
            if (ex_valid && ex_ready) ek++;
            if (lgrant) wr_l++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL full_timeout got full=%b released=0 required released=1", was_full);
        end
        ex_valid = 1'b0; lsu_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_x0;
        @(negedge clk);
        ex_valid = 1'b1; ex_wa = 5'd0; ex_wd = 32'h0000_1234;
        #1;
        total++;
        if (rf_wen !== 1'b0 || pend_vec !== 32'd0) begin
            bad++;
            $display("FAIL x0_push got wen=%b pend=%h required 0 0", rf_wen, pend_vec);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        total++;
`ifdef WB_ARB_BYPASS_EN
        if (rf_wen !== 1'b0 || pend_vec !== 32'd0 || idle !== 1'b1) begin
`else
        if (rf_wen !== 1'b0 || pend_vec !== 32'd0 || idle !== 1'b0) begin
`endif
            bad++;
            $display("FAIL x0_pop got wen=%b pend=%h idle=%b", rf_wen, pend_vec, idle);
        end
        @(negedge clk);
        #1;
        total++;
        if (idle !== 1'b1 || pend_vec !== 32'd0) begin
            bad++;
            $display("FAIL x0_drained got idle=%b pend=%h required 1 0", idle, pend_vec);
        end
    endtask

    task automatic test_waw;
`ifdef WB_ARB_BYPASS_EN
        bit exp_p[3] = '{1'b1, 1'b0, 1'b0};
        bit exp_w[3] = '{1'b1, 1'b0, 1'b0};
`else
        bit exp_p[3] = '{1'b1, 1'b1, 1'b0};
        bit exp_w[3] = '{1'b1, 1'b1, 1'b0};
`endif
        @(negedge clk);
        ex_valid = 1'b1;  ex_wa = 5'd7;  ex_wd = 32'h7777_0001;
        lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 32'h7777_0002;
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_valid = 1'b0; lsu_valid = 1'b0;
            #1;
            total++;
            if (pend_vec[7] !== exp_p[c] || rf_wen !== exp_w[c] || (exp_w[c] && rf_wa !== 5'd7)) begin
                bad++;
                $display("FAIL waw_step%0d got pend7=%b wen=%b wa=%0d required pend7=%b wen=%b wa=7",
                         c, pend_vec[7], rf_wen, rf_wa, exp_p[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ex_valid = 1'b1;  ex_wa = 5'd3;  ex_wd = 32'h3333_3333;
        lsu_valid = 1'b1; lsu_wa = 5'd4; lsu_wd = 32'h4444_4444;
        @(negedge clk);
        ex_wa = 5'd5;  ex_wd = 32'h5555_5555;
        lsu_wa = 5'd6; lsu_wd = 32'h6666_6666;
        @(negedge clk);
        ex_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b1;
        #1;
        total++;
        if (rf_wen !== 1'b0 || idle !== 1'b1 || pend_vec !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_during got wen=%b idle=%b pend=%h required 0 1 0", rf_wen, idle, pend_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (rf_wen !== 1'b0 || idle !== 1'b1 || pend_vec !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_after got wen=%b idle=%b pend=%h required 0 1 0", rf_wen, idle, pend_vec);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (rf_wen !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_discard cycle=%0d got wen=%b required 0", c, rf_wen);
            end
        end
    endtask

    task automatic test_random;
        bit ex_acc = 1'b1;
        bit l_acc  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 79) == 0);
            if (ex_acc || !ex_valid) begin
                ex_valid = ($urandom_range(0, 3) != 0);
                ex_wa    = 5'($urandom_range(0, 9));
                ex_wd    = $urandom;
            end
            if (l_acc || !lsu_valid) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_wa    = 5'($urandom_range(0, 9));
                lsu_wd    = $urandom;
            end
            #1;
            ex_acc = ex_valid && ex_ready;
            l_acc  = lsu_valid && lsu_ready;
        end
        @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0;  ex_wa = 5'd0;  ex_wd = 32'd0;
        lsu_valid = 1'b0; lsu_wa = 5'd0; lsu_wd = 32'd0;
        test_reset();
        test_single();
        apply_reset();
        test_alternate();
        test_full();
        test_x0();
        test_waw();
        test_reset_mid();
        test_random();
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
